ctrl_pipeline: RTL and testbench

//   Consumer side of the decode-stage control bundles (EX/MEM/WB). Carries each decoded

---
 rtl/ctrl_pipeline_pkg.sv | 82 ++++++++
 rtl/ctrl_pipeline_if.sv | 42 ++++
 rtl/ctrl_pipeline_stage_reg.sv | 33 +++
 rtl/ctrl_pipeline.sv | 129 ++++++++++++
 tb/tb_ctrl_pipeline.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pipeline_pkg.sv
// Shared definitions for the control pipeline: bundle widths, bundle bit positions,
// forwarding-select encodings, stage register layouts and their bubble constants.
package ctrl_pipeline_pkg;

  localparam int unsigned REG_AW = 5;  // register index width
  localparam int unsigned EX_W   = 5;  // {ALUop(3), ALUsrc(1), RegDst(1)}
  localparam int unsigned MEM_W  = 2;  // {MEM_cs(1), MEM_we(1)}
  localparam int unsigned WB_W   = 1;  // {Reg_we(1)}

  // EX bundle bit positions
  localparam int unsigned EX_ALUOP_MSB = 4;
  localparam int unsigned EX_ALUOP_LSB = 2;
  localparam int unsigned EX_ALUSRC    = 1;
  localparam int unsigned EX_REGDST    = 0;

  // MEM bundle bit positions
  localparam int unsigned MEM_CS = 1;
  localparam int unsigned MEM_WE = 0;

  // WB bundle bit positions
  localparam int unsigned WB_REG_WE = 0;

  // Operand select encodings
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [EX_W-1:0]   ex;
    logic [MEM_W-1:0]  mem;
    logic [WB_W-1:0]   wb;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic              valid;
    logic [MEM_W-1:0]  mem;
    logic [WB_W-1:0]   wb;
    logic [REG_AW-1:0] dst;
  } ex_mem_t;

  typedef struct packed {
    logic              valid;
    logic [WB_W-1:0]   wb;
    logic              mem_to_reg;
    logic [REG_AW-1:0] dst;
  } mem_wb_t;

  // A bubble is an all-zero stage: not valid, no strobes, register 0.
  localparam id_ex_t  ID_EX_BUBBLE  = '0;
  localparam ex_mem_t EX_MEM_BUBBLE = '0;
  localparam mem_wb_t MEM_WB_BUBBLE = '0;

  function automatic logic [EX_W-1:0] make_ex(logic [2:0] alu_op, logic alu_src,
                                               logic reg_dst);
    logic [EX_W-1:0] r;
    r = '0;
    r[EX_ALUOP_MSB:EX_ALUOP_LSB] = alu_op;
    r[EX_ALUSRC]                 = alu_src;
    r[EX_REGDST]                 = reg_dst;
    return r;
  endfunction

  // Memory read: chip select without write enable.
  function automatic logic is_load(logic [MEM_W-1:0] mem);
    return mem[MEM_CS] & ~mem[MEM_WE];
  endfunction

  // EX/MEM result is younger than MEM/WB, so it wins.
  function automatic logic [1:0] fwd_sel(logic mem_hit, logic wb_hit);
    if (mem_hit) begin
      return FWD_MEM;
    end else if (wb_hit) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Decode-to-pipeline control bus.
//   slave  : the pipeline (consumes decode bundles, drives stage control and hazard info)
//   master : the decode side (drives decode bundles and flush, observes stage control)
interface ctrl_pipeline_if;

  logic                                   id_valid_i;
  logic [ctrl_pipeline_pkg::EX_W-1:0]     id_ex_ctrl_i;
  logic [ctrl_pipeline_pkg::MEM_W-1:0]    id_mem_ctrl_i;
  logic [ctrl_pipeline_pkg::WB_W-1:0]     id_wb_ctrl_i;
  logic [ctrl_pipeline_pkg::REG_AW-1:0]   id_rs_i;
  logic [ctrl_pipeline_pkg::REG_AW-1:0]   id_rt_i;
  logic [ctrl_pipeline_pkg::REG_AW-1:0]   id_rd_i;
  logic                                   flush_i;

  logic [ctrl_pipeline_pkg::EX_W-1:0]     ex_ctrl_o;
  logic [ctrl_pipeline_pkg::REG_AW-1:0]   ex_rs_o;
  logic [ctrl_pipeline_pkg::REG_AW-1:0]   ex_rt_o;
  logic [ctrl_pipeline_pkg::REG_AW-1:0]   ex_dst_o;
  logic [ctrl_pipeline_pkg::MEM_W-1:0]    mem_ctrl_o;
  logic [ctrl_pipeline_pkg::REG_AW-1:0]   mem_dst_o;
  logic                                   wb_we_o;
  logic                                   wb_mem_to_reg_o;
  logic [ctrl_pipeline_pkg::REG_AW-1:0]   wb_dst_o;
  logic                                   stall_o;
  logic [1:0]                             fwd_a_o;
  logic [1:0]                             fwd_b_o;

  modport slave (
    input  id_valid_i, id_ex_ctrl_i, id_mem_ctrl_i, id_wb_ctrl_i,
    input  id_rs_i, id_rt_i, id_rd_i, flush_i,
    output ex_ctrl_o, ex_rs_o, ex_rt_o, ex_dst_o, mem_ctrl_o, mem_dst_o,
    output wb_we_o, wb_mem_to_reg_o, wb_dst_o, stall_o, fwd_a_o, fwd_b_o
  );

  modport master (
    output id_valid_i, id_ex_ctrl_i, id_mem_ctrl_i, id_wb_ctrl_i,
    output id_rs_i, id_rt_i, id_rd_i, flush_i,
    input  ex_ctrl_o, ex_rs_o, ex_rt_o, ex_dst_o, mem_ctrl_o, mem_dst_o,
    input  wb_we_o, wb_mem_to_reg_o, wb_dst_o, stall_o, fwd_a_o, fwd_b_o
  );

endinterface

// File: rtl/ctrl_pipeline_stage_reg.sv
// Generic pipeline stage register with asynchronous active-low reset.
// Each edge it loads either d_i or the bubble value (bubble_i=1).
//   clk_i     clock, rising edge
//   rst_n_i   asynchronous active-low reset, clears to BubbleVal
//   bubble_i  load BubbleVal instead of d_i
//   d_i       next stage contents
//   q_o       current stage contents
module pipe_stage_reg #(
  parameter int unsigned      Width     = 8,
  parameter logic [Width-1:0] BubbleVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             bubble_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stage_q <= BubbleVal;
    end else if (bubble_i) begin
      stage_q <= BubbleVal;
    end else begin
      stage_q <= d_i;
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/ctrl_pipeline.sv
// Control pipeline: carries decoded EX/MEM/WB control bundles and register indices through
// the ID/EX, EX/MEM and MEM/WB stage registers, inserts bubbles on flush and load-use
// stall, and produces operand-forwarding selects.
//   clk_i    clock, rising edge
//   rst_n_i  asynchronous active-low reset; empties every stage
//   bus      ctrl_pipeline_if.slave: decode bundles/indices and flush in; per-stage control,
//            destinations, stall request and fwd_a/fwd_b selects out
module ctrl_pipeline
  import ctrl_pipeline_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  ctrl_pipeline_if.slave    bus
);

  id_ex_t  id_ex_d,  id_ex_q;
  ex_mem_t ex_mem_d, ex_mem_q;
  mem_wb_t mem_wb_d, mem_wb_q;

  logic [REG_AW-1:0] ex_dst;
  logic              load_in_ex;
  logic              stall;
  logic              id_bubble;
  logic              mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic              mem_writes, wb_writes;

  // ---------------------------------------------------------------------------
  // Hazard detection and next-stage contents
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_dst     = id_ex_q.ex[EX_REGDST] ? id_ex_q.rd : id_ex_q.rt;
    load_in_ex = id_ex_q.valid & is_load(id_ex_q.mem);

    // rt is compared for every opcode: occasionally stalls needlessly, never misses.
    stall = load_in_ex & (ex_dst != '0) & bus.id_valid_i & ~bus.flush_i &
            ((ex_dst == bus.id_rs_i) | (ex_dst == bus.id_rt_i));

    id_bubble = bus.flush_i | stall | ~bus.id_valid_i;

    id_ex_d = '{
      valid: 1'b1,
      ex:    bus.id_ex_ctrl_i,
      mem:   bus.id_mem_ctrl_i,
      wb:    bus.id_wb_ctrl_i,
      rs:    bus.id_rs_i,
      rt:    bus.id_rt_i,
      rd:    bus.id_rd_i
    };

    ex_mem_d = '{
      valid: id_ex_q.valid,
      mem:   id_ex_q.mem,
      wb:    id_ex_q.wb,
      dst:   ex_dst
    };

    mem_wb_d = '{
      valid:      ex_mem_q.valid,
      wb:         ex_mem_q.wb,
      mem_to_reg: is_load(ex_mem_q.mem),
      dst:        ex_mem_q.dst
    };
  end

  // ---------------------------------------------------------------------------
  // Stage registers; only ID/EX can take a bubble, later stages always advance
  // ---------------------------------------------------------------------------
  pipe_stage_reg #(
    .Width     ($bits(id_ex_t)),
    .BubbleVal (ID_EX_BUBBLE)
  ) u_id_ex (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .bubble_i (id_bubble),
    .d_i      (id_ex_d),
    .q_o      (id_ex_q)
  );

  pipe_stage_reg #(
    .Width     ($bits(ex_mem_t)),
    .BubbleVal (EX_MEM_BUBBLE)
  ) u_ex_mem (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .bubble_i (1'b0),
    .d_i      (ex_mem_d),
    .q_o      (ex_mem_q)
  );

  pipe_stage_reg #(
    .Width     ($bits(mem_wb_t)),
    .BubbleVal (MEM_WB_BUBBLE)
  ) u_mem_wb (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .bubble_i (1'b0),
    .d_i      (mem_wb_d),
    .q_o      (mem_wb_q)
  );

  // ---------------------------------------------------------------------------
  // Forwarding: only valid, register-writing, non-r0 producers qualify
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_writes = ex_mem_q.valid & ex_mem_q.wb[WB_REG_WE] & (ex_mem_q.dst != '0);
    wb_writes  = mem_wb_q.valid & mem_wb_q.wb[WB_REG_WE] & (mem_wb_q.dst != '0);
    mem_hit_a  = mem_writes & (ex_mem_q.dst == id_ex_q.rs);
    mem_hit_b  = mem_writes & (ex_mem_q.dst == id_ex_q.rt);
    wb_hit_a   = wb_writes & (mem_wb_q.dst == id_ex_q.rs);
    wb_hit_b   = wb_writes & (mem_wb_q.dst == id_ex_q.rt);
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.ex_ctrl_o       = id_ex_q.ex;
  assign bus.ex_rs_o         = id_ex_q.rs;
  assign bus.ex_rt_o         = id_ex_q.rt;
  assign bus.ex_dst_o        = ex_dst;
  assign bus.mem_ctrl_o      = ex_mem_q.mem;
  assign bus.mem_dst_o       = ex_mem_q.dst;
  assign bus.wb_we_o         = mem_wb_q.valid & mem_wb_q.wb[WB_REG_WE];
  assign bus.wb_mem_to_reg_o = mem_wb_q.mem_to_reg;
  assign bus.wb_dst_o        = mem_wb_q.dst;
  assign bus.stall_o         = stall;
  assign bus.fwd_a_o         = fwd_sel(mem_hit_a, wb_hit_a);
  assign bus.fwd_b_o         = fwd_sel(mem_hit_b, wb_hit_b);

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline. An instruction-level model predicts every output
// for each cycle; predictions are queued and a negedge monitor compares them.
module tb_ctrl_pipeline;
  import ctrl_pipeline_pkg::*;

  localparam int K_ADD  = 0;
  localparam int K_ADDI = 1;
  localparam int K_LW   = 2;
  localparam int K_SW   = 3;
  localparam int K_BEQ  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ctrl_pipeline_if bus ();

  ctrl_pipeline dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         valid;
    int         kind;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } ins_t;

  typedef struct {
    int          cyc;
    logic [19:0] ex;
    logic [6:0]  mem;
    logic [6:0]  wb;
    logic [4:0]  haz;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  ins_t m_ex, m_mem, m_wb;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Decoder-side encodings of each instruction kind
  function automatic logic [4:0] enc_ex(int k);
    case (k)
      K_ADD:   return make_ex(3'b010, 1'b0, 1'b1);
      K_ADDI:  return make_ex(3'b010, 1'b1, 1'b0);
      K_LW:    return make_ex(3'b000, 1'b1, 1'b0);
      K_SW:    return make_ex(3'b000, 1'b1, 1'b0);
      default: return make_ex(3'b110, 1'b0, 1'b0);
    endcase
  endfunction

  function automatic logic [1:0] enc_mem(int k);
    if (k == K_LW) return 2'b10;
    if (k == K_SW) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit kind_writes(int k);
    return (k == K_ADD) || (k == K_ADDI) || (k == K_LW);
  endfunction

  // Instruction-level semantics
  function automatic ins_t bubble();
    ins_t b;
    b.valid = 1'b0; b.kind = K_BEQ; b.rs = '0; b.rt = '0; b.rd = '0;
    return b;
  endfunction

  function automatic logic [4:0] dst_of(ins_t i);
    if (!i.valid) return 5'd0;
    return (i.kind == K_ADD) ? i.rd : i.rt;
  endfunction

  function automatic bit writes(ins_t i);
    return i.valid && kind_writes(i.kind);
  endfunction

  function automatic logic [1:0] fwd_of(logic [4:0] r);
    if (r != 0 && writes(m_mem) && dst_of(m_mem) == r) return 2'b10;
    if (r != 0 && writes(m_wb) && dst_of(m_wb) == r) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One decode cycle: drive inputs, predict this cycle's outputs, then advance the model.
  task automatic issue(input int kind, input int rs, input int rt, input int rd,
                       input bit valid = 1'b1, input bit flush = 1'b0);
    ins_t       in;
    exp_t       e;
    logic [4:0] xd;
    bit         stall;
    @(posedge clk);
    #1;
    in.valid = valid; in.kind = kind;
    in.rs = 5'(rs); in.rt = 5'(rt); in.rd = 5'(rd);
    bus.id_valid_i    = valid;
    bus.id_ex_ctrl_i  = enc_ex(kind);
    bus.id_mem_ctrl_i = enc_mem(kind);
    bus.id_wb_ctrl_i  = kind_writes(kind) ? 1'b1 : 1'b0;
    bus.id_rs_i       = in.rs;
    bus.id_rt_i       = in.rt;
    bus.id_rd_i       = in.rd;
    bus.flush_i       = flush;

    xd    = dst_of(m_ex);
    stall = m_ex.valid && m_ex.kind == K_LW && xd != 0 && valid && !flush &&
            (xd == in.rs || xd == in.rt);
    e.cyc = cyc;
    e.ex  = {m_ex.valid ? enc_ex(m_ex.kind) : 5'd0, m_ex.rs, m_ex.rt, xd};
    e.mem = {m_mem.valid ? enc_mem(m_mem.kind) : 2'b00, dst_of(m_mem)};
    e.wb  = {writes(m_wb), m_wb.valid && m_wb.kind == K_LW, dst_of(m_wb)};
    e.haz = {stall, fwd_of(m_ex.rs), fwd_of(m_ex.rt)};
    exp_q.push_back(e);

    m_wb  = m_mem;
    m_mem = m_ex;
    m_ex  = (flush || stall || !valid) ? bubble() : in;
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) issue(K_BEQ, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic idle_inputs();
    bus.id_valid_i = 1'b0; bus.id_ex_ctrl_i = '0; bus.id_mem_ctrl_i = '0;
    bus.id_wb_ctrl_i = '0; bus.id_rs_i = '0; bus.id_rt_i = '0; bus.id_rd_i = '0;
    bus.flush_i = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {bus.ex_ctrl_o, bus.ex_rs_o, bus.ex_rt_o, bus.ex_dst_o, bus.mem_ctrl_o,
                 bus.mem_dst_o, bus.wb_we_o, bus.wb_mem_to_reg_o, bus.wb_dst_o,
                 bus.stall_o, bus.fwd_a_o, bus.fwd_b_o}, 64'd0);
  endtask

  // Asynchronous reset between cycles; outputs must clear without a clock edge.
  task automatic do_reset(input string name);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check_all_zero(name);
    m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check($sformatf("ex_stage c%0d", mon_e.cyc),
            {bus.ex_ctrl_o, bus.ex_rs_o, bus.ex_rt_o, bus.ex_dst_o}, 64'(mon_e.ex));
      check($sformatf("mem_stage c%0d", mon_e.cyc),
            {bus.mem_ctrl_o, bus.mem_dst_o}, 64'(mon_e.mem));
      check($sformatf("wb_stage c%0d", mon_e.cyc),
            {bus.wb_we_o, bus.wb_mem_to_reg_o, bus.wb_dst_o}, 64'(mon_e.wb));
      check($sformatf("hazard c%0d", mon_e.cyc),
            {bus.stall_o, bus.fwd_a_o, bus.fwd_b_o}, 64'(mon_e.haz));
    end
  end

  initial begin
    m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
    idle_inputs();
    #1;
    check_all_zero("reset_init");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Back-to-back dependency: EX/MEM forward on both operands
    issue(K_ADD, 1, 2, 3);
    issue(K_ADD, 3, 3, 4);
    idle(1);
    check("fwd_a_b2b", bus.fwd_a_o, 64'h2);
    check("fwd_b_b2b", bus.fwd_b_o, 64'h2);
    idle(3);

    // One unrelated instruction between: MEM/WB forward
    issue(K_ADD, 1, 2, 3);
    issue(K_ADDI, 6, 7, 0);
    issue(K_ADD, 3, 3, 4);
    idle(1);
    check("fwd_a_gap1", bus.fwd_a_o, 64'h1);
    check("fwd_b_gap1", bus.fwd_b_o, 64'h1);
    idle(3);

    // Load-use: one stall cycle, bubble in EX, then MEM/WB forward
    issue(K_LW, 1, 5, 0);
    issue(K_ADD, 5, 2, 6);
    check("lu_stall", bus.stall_o, 64'h1);
    issue(K_ADD, 5, 2, 6);
    check("lu_stall_once", bus.stall_o, 64'h0);
    check("lu_bubble", bus.ex_ctrl_o, 64'h0);
    idle(1);
    check("lu_fwd_a", bus.fwd_a_o, 64'h1);
    check("lu_mem_to_reg", bus.wb_mem_to_reg_o, 64'h1);
    idle(3);

    // r0 never forwards or stalls
    issue(K_ADDI, 1, 0, 0);
    issue(K_ADD, 0, 0, 8);
    idle(1);
    check("r0_fwd", {bus.stall_o, bus.fwd_a_o, bus.fwd_b_o}, 64'h0);
    issue(K_LW, 1, 0, 0);
    issue(K_ADD, 0, 0, 9);
    check("r0_no_stall", bus.stall_o, 64'h0);
    idle(3);

    // Flush together with load-use hazard
    issue(K_LW, 1, 5, 0);
    issue(K_ADD, 5, 5, 6, 1'b1, 1'b1);
    check("flush_no_stall", bus.stall_o, 64'h0);
    idle(1);
    check("flush_ex_bubble", bus.ex_ctrl_o, 64'h0);
    idle(2);
    check("flush_wb_we", bus.wb_we_o, 64'h0);
    idle(3);

    // Store never forwards
    issue(K_SW, 1, 9, 0);
    issue(K_ADD, 9, 9, 10);
    idle(1);
    check("sw_mem_ctrl", bus.mem_ctrl_o, 64'h3);
    check("sw_no_fwd", {bus.fwd_a_o, bus.fwd_b_o}, 64'h0);
    idle(3);

    // Reset with three ADDs in flight
    issue(K_ADD, 1, 2, 3);
    issue(K_ADD, 1, 2, 4);
    issue(K_ADD, 1, 2, 5);
    do_reset("reset_mid");
    idle(1);
    check("reset_first_edge_wb_we", bus.wb_we_o, 64'h0);
    check("reset_first_edge_mem", bus.mem_ctrl_o, 64'h0);

    // Randomized stream over a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        do_reset("reset_random");
      end
      issue(int'($urandom_range(0, 4)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10);
    end

    repeat (2) @(negedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
